// File: rtl/grf_mp_pkg.sv
// Shared defaults, lane-count helper and trace-record layout for the multi-port GRF.
package grf_pkg;

   localparam int unsigned GRF_DW     = 32;
   localparam int unsigned GRF_DEPTH  = 32;
   localparam int unsigned GRF_NUM_RD = 2;

   function automatic int unsigned grf_lanes(input int unsigned dw);
      return dw / 8;
   endfunction

   typedef struct packed {
      logic                         valid;
      logic [$clog2(GRF_DEPTH)-1:0] addr;
      logic [GRF_DW-1:0]            data;
   } grf_trace_t;

endpackage

// File: rtl/grf_mp_if.sv
// Read/write/trace bus of the multi-port GRF; master = pipeline side, slave = register file.
interface grf_mp_if
   import grf_pkg::*;
#(
   parameter int unsigned DW     = GRF_DW,
   parameter int unsigned DEPTH  = GRF_DEPTH,
   parameter int unsigned NUM_RD = GRF_NUM_RD
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NB = grf_lanes(DW);

   logic [NUM_RD*AW-1:0] RA;
   logic [NUM_RD*DW-1:0] RD;
   logic [NB-1:0]        WE0;
   logic [AW-1:0]        WA0;
   logic [DW-1:0]        WD0;
   logic [NB-1:0]        WE1;
   logic [AW-1:0]        WA1;
   logic [DW-1:0]        WD1;
   logic                 TrValid;
   logic [AW-1:0]        TrAddr;
   logic [DW-1:0]        TrData;
   logic [31:0]          WrCount;

   modport master (
      output RA, WE0, WA0, WD0, WE1, WA1, WD1,
      input  RD, TrValid, TrAddr, TrData, WrCount
   );

   modport slave (
      input  RA, WE0, WA0, WD0, WE1, WA1, WD1,
      output RD, TrValid, TrAddr, TrData, WrCount
   );

endinterface

// File: rtl/grf_mp_lane_merge.sv
// Per-byte merge of two write ports onto an old word; W1 wins lanes both ports enable.
module grf_lane_merge
   import grf_pkg::*;
#(
   parameter int unsigned DW = GRF_DW
) (
   input  logic [DW-1:0]            i_old,
   input  logic [grf_lanes(DW)-1:0] i_we0,
   input  logic [DW-1:0]            i_wd0,
   input  logic [grf_lanes(DW)-1:0] i_we1,
   input  logic [DW-1:0]            i_wd1,
   output logic [DW-1:0]            o_word
);
   localparam int unsigned NB = grf_lanes(DW);

   always_comb begin
      o_word = i_old;
      for (int unsigned b = 0; b < NB; b++) begin
         if (i_we1[b])
            o_word[8*b +: 8] = i_wd1[8*b +: 8];
         else if (i_we0[b])
            o_word[8*b +: 8] = i_wd0[8*b +: 8];
      end
   end

endmodule

// File: rtl/grf_mp.sv
// Parametrised register file: NUM_RD combinational read ports, two byte-enabled write
// ports, optional bypass and zero register, plus a registered write trace and counter.
module grf_mp
   import grf_pkg::*;
#(
   parameter int unsigned DW       = GRF_DW,
   parameter int unsigned DEPTH    = GRF_DEPTH,
   parameter int unsigned NUM_RD   = GRF_NUM_RD,
   parameter bit          BYPASS   = 1'b1,
   parameter bit          ZERO_REG = 1'b1
) (
   input logic     Clock,
   input logic     Reset,
   grf_mp_if.slave io_grf
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NB = grf_lanes(DW);

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } trace_t;

   logic [DW-1:0] r_mem [DEPTH];
   trace_t        r_trace;
   logic [31:0]   r_wr_count;

   logic          w_c0;
   logic          w_c1;
   logic          w_coll;
   logic [NB-1:0] w_st0_we1;
   logic [NB-1:0] w_st1_we0;
   logic [DW-1:0] w_m0;
   logic [DW-1:0] w_m1;
   logic [DW-1:0] w_rd [NUM_RD];

   assign w_c0 = (|io_grf.WE0) && !Reset && !(ZERO_REG && io_grf.WA0 == '0);
   assign w_c1 = (|io_grf.WE1) && !Reset && !(ZERO_REG && io_grf.WA1 == '0);
   assign w_coll = w_c0 && w_c1 && (io_grf.WA0 == io_grf.WA1);

   // On a collision both merges see both ports, so each yields the same final word.
   assign w_st0_we1 = w_coll ? io_grf.WE1 : '0;
   assign w_st1_we0 = w_coll ? io_grf.WE0 : '0;

   grf_lane_merge #(.DW(DW)) u_merge_w0 (
      .i_old  (r_mem[io_grf.WA0]),
      .i_we0  (io_grf.WE0),
      .i_wd0  (io_grf.WD0),
      .i_we1  (w_st0_we1),
      .i_wd1  (io_grf.WD1),
      .o_word (w_m0)
   );

   grf_lane_merge #(.DW(DW)) u_merge_w1 (
      .i_old  (r_mem[io_grf.WA1]),
      .i_we0  (w_st1_we0),
      .i_wd0  (io_grf.WD0),
      .i_we1  (io_grf.WE1),
      .i_wd1  (io_grf.WD1),
      .o_word (w_m1)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
         r_trace    <= '0;
         r_wr_count <= '0;
      end else begin
         if (w_c0)
            r_mem[io_grf.WA0] <= w_m0;
         if (w_c1)
            r_mem[io_grf.WA1] <= w_m1;
         r_trace.valid <= w_c0 || w_c1;
         if (w_c1) begin
            r_trace.addr <= io_grf.WA1;
            r_trace.data <= w_m1;
         end else if (w_c0) begin
            r_trace.addr <= io_grf.WA0;
            r_trace.data <= w_m0;
         end
         r_wr_count <= r_wr_count + 32'(w_c0) + 32'(w_c1);
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [AW-1:0] w_ra;
      logic [NB-1:0] w_we0;
      logic [NB-1:0] w_we1;
      logic [DW-1:0] w_byp;

      assign w_ra  = io_grf.RA[k*AW +: AW];
      // Commit flags already exclude Reset, so bypass is off while in reset.
      assign w_we0 = (BYPASS && w_c0 && io_grf.WA0 == w_ra) ? io_grf.WE0 : '0;
      assign w_we1 = (BYPASS && w_c1 && io_grf.WA1 == w_ra) ? io_grf.WE1 : '0;

      grf_lane_merge #(.DW(DW)) u_merge_rd (
         .i_old  (r_mem[w_ra]),
         .i_we0  (w_we0),
         .i_wd0  (io_grf.WD0),
         .i_we1  (w_we1),
         .i_wd1  (io_grf.WD1),
         .o_word (w_byp)
      );

      assign w_rd[k] = (ZERO_REG && w_ra == '0) ? '0 : w_byp;
   end

   always_comb begin
      io_grf.RD = '0;
      for (int unsigned k = 0; k < NUM_RD; k++)
         io_grf.RD[k*DW +: DW] = w_rd[k];
   end

   assign io_grf.TrValid = r_trace.valid;
   assign io_grf.TrAddr  = r_trace.addr;
   assign io_grf.TrData  = r_trace.data;
   assign io_grf.WrCount = r_wr_count;

endmodule

// File: tb/tb_grf_mp.sv
// Scoreboarded directed bench for grf_mp: bypassing and non-bypassing builds share stimulus.
module tb_grf_mp;
   import grf_pkg::*;

   localparam int unsigned DW     = 32;
   localparam int unsigned DEPTH  = 32;
   localparam int unsigned NUM_RD = 2;
   localparam int unsigned AW     = 5;
   localparam int unsigned NB     = 4;

   typedef struct packed {
      grf_trace_t  tr;
      logic [31:0] cnt;
   } exp_t;

   logic Clock = 1'b0;
   logic Reset;
   always #5 Clock = ~Clock;

   logic [AW-1:0] ra0, ra1, wa0, wa1;
   logic [NB-1:0] we0, we1;
   logic [DW-1:0] wd0, wd1;

   int          checks = 0;
   int          errors = 0;
   exp_t        sbq[$];
   grf_trace_t  exp_tr = '0;
   logic [31:0] exp_cnt = '0;

   grf_mp_if #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) ifb ();
   grf_mp_if #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) ifn ();

   assign ifb.RA  = {ra1, ra0};
   assign ifb.WE0 = we0;
   assign ifb.WA0 = wa0;
   assign ifb.WD0 = wd0;
   assign ifb.WE1 = we1;
   assign ifb.WA1 = wa1;
   assign ifb.WD1 = wd1;
   assign ifn.RA  = {ra1, ra0};
   assign ifn.WE0 = we0;
   assign ifn.WA0 = wa0;
   assign ifn.WD0 = wd0;
   assign ifn.WE1 = we1;
   assign ifn.WA1 = wa1;
   assign ifn.WD1 = wd1;

   grf_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_b (
      .Clock  (Clock),
      .Reset  (Reset),
      .io_grf (ifb.slave)
   );

   grf_mp #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_n (
      .Clock  (Clock),
      .Reset  (Reset),
      .io_grf (ifn.slave)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reads are combinational: compare both builds after inputs settle.
   task automatic chk_rd(input string name, input int unsigned k,
                         input logic [DW-1:0] exp_b, input logic [DW-1:0] exp_n);
      #1;
      check({name, "_byp"},   64'(ifb.RD[k*DW +: DW]), 64'(exp_b));
      check({name, "_nobyp"}, 64'(ifn.RD[k*DW +: DW]), 64'(exp_n));
   endtask

   // Queue the expected trace/count for the coming edge, then take the edge.
   task automatic clk_edge(input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int unsigned inc);
      exp_t e;
      if (Reset) begin
         exp_tr  = '0;
         exp_cnt = '0;
      end else begin
         exp_tr.valid = v;
         if (v) begin
            exp_tr.addr = a;
            exp_tr.data = d;
         end
         exp_cnt = exp_cnt + inc;
      end
      e.tr  = exp_tr;
      e.cnt = exp_cnt;
      sbq.push_back(e);
      @(posedge Clock);
      #1;
   endtask

   task automatic idle();
      we0 = '0;
      we1 = '0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge Clock);
         #2;
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("trvalid_b", 64'(ifb.TrValid), 64'(e.tr.valid));
            check("traddr_b",  64'(ifb.TrAddr),  64'(e.tr.addr));
            check("trdata_b",  64'(ifb.TrData),  64'(e.tr.data));
            check("wrcount_b", 64'(ifb.WrCount), 64'(e.cnt));
            check("trvalid_n", 64'(ifn.TrValid), 64'(e.tr.valid));
            check("traddr_n",  64'(ifn.TrAddr),  64'(e.tr.addr));
            check("trdata_n",  64'(ifn.TrData),  64'(e.tr.data));
            check("wrcount_n", 64'(ifn.WrCount), 64'(e.cnt));
         end
      end
   end

   initial begin : stimulus
      Reset = 1'b1;
      ra0 = 5'd5; ra1 = 5'd6;
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
      idle();
      clk_edge(1'b0, '0, '0, 0);
      clk_edge(1'b0, '0, '0, 0);
      chk_rd("reset_rd0", 0, 32'h0, 32'h0);
      chk_rd("reset_rd1", 1, 32'h0, 32'h0);

      // Fill r[i] = i+1; r0 write is dropped.
      Reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         we0 = 4'hF;
         wa0 = AW'(i);
         wd0 = DW'(i + 1);
         clk_edge(i != 0, AW'(i), DW'(i + 1), (i != 0) ? 1 : 0);
      end
      idle();
      ra0 = 5'd5; ra1 = 5'd6;
      chk_rd("fill_r5", 0, 32'd6, 32'd6);
      chk_rd("fill_r6", 1, 32'd7, 32'd7);
      clk_edge(1'b0, '0, '0, 0);
      ra0 = 5'd0; ra1 = 5'd31;
      chk_rd("fill_r0", 0, 32'd0, 32'd0);
      chk_rd("fill_r31", 1, 32'd32, 32'd32);

      // Byte merge on r3.
      we0 = 4'hF; wa0 = 5'd3; wd0 = 32'h11223344;
      clk_edge(1'b1, 5'd3, 32'h11223344, 1);
      we0 = 4'b0101; wd0 = 32'hAABBCCDD; ra0 = 5'd3;
      chk_rd("merge_bypass", 0, 32'h11BB33DD, 32'h11223344);
      clk_edge(1'b1, 5'd3, 32'h11BB33DD, 1);
      idle();
      chk_rd("merge_after", 0, 32'h11BB33DD, 32'h11BB33DD);

      // Collision on r7.
      we0 = 4'hF; wa0 = 5'd7; wd0 = 32'h0;
      clk_edge(1'b1, 5'd7, 32'h0, 1);
      we1 = 4'b1100; wa1 = 5'd7; wd1 = 32'hFFFF0000; ra1 = 5'd7;
      chk_rd("coll_bypass", 1, 32'hFFFF0000, 32'h0);
      clk_edge(1'b1, 5'd7, 32'hFFFF0000, 2);
      we0 = 4'b0011; wd0 = 32'h99881234;
      we1 = 4'b0110; wd1 = 32'h00ABCD00;
      chk_rd("coll_mix_bypass", 1, 32'hFFABCD34, 32'hFFFF0000);
      clk_edge(1'b1, 5'd7, 32'hFFABCD34, 2);
      idle();
      chk_rd("coll_mix_after", 1, 32'hFFABCD34, 32'hFFABCD34);

      // Distinct addresses on both ports: trace follows W1.
      we0 = 4'hF; wa0 = 5'd12; wd0 = 32'h0000000C;
      we1 = 4'hF; wa1 = 5'd13; wd1 = 32'h0000000D;
      ra0 = 5'd12; ra1 = 5'd13;
      clk_edge(1'b1, 5'd13, 32'h0000000D, 2);
      idle();
      chk_rd("dual_r12", 0, 32'h0C, 32'h0C);
      chk_rd("dual_r13", 1, 32'h0D, 32'h0D);

      // W1 bypass on r9.
      we1 = 4'hF; wa1 = 5'd9; wd1 = 32'hDEADBEEF; ra0 = 5'd9;
      chk_rd("bypass_r9", 0, 32'hDEADBEEF, 32'd10);
      clk_edge(1'b1, 5'd9, 32'hDEADBEEF, 1);
      idle();
      chk_rd("bypass_r9_after", 0, 32'hDEADBEEF, 32'hDEADBEEF);

      // Zero register ignores writes.
      we0 = 4'hF; wa0 = 5'd0; wd0 = 32'h12345678; ra0 = 5'd0;
      chk_rd("zero_same", 0, 32'h0, 32'h0);
      clk_edge(1'b0, '0, '0, 0);
      idle();
      chk_rd("zero_after", 0, 32'h0, 32'h0);
      clk_edge(1'b0, '0, '0, 0);

      // Reset with a pending write.
      Reset = 1'b1;
      we0 = 4'hF; wa0 = 5'd10; wd0 = 32'h55; ra0 = 5'd10; ra1 = 5'd7;
      chk_rd("rst_storage", 0, 32'd11, 32'd11);
      clk_edge(1'b0, '0, '0, 0);
      Reset = 1'b0;
      idle();
      chk_rd("rst_r10", 0, 32'h0, 32'h0);
      chk_rd("rst_r7", 1, 32'h0, 32'h0);
      clk_edge(1'b0, '0, '0, 0);

      #10;
      check("scoreboard_drained", 64'(sbq.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised general-purpose register file, the successor to the fixed 32x32 single-write GRF.
- Sits in the decode/writeback stage of the pipelined CPU.
- Adds a configurable number of read ports, two write ports (W0 = ALU/writeback, W1 = late load/MDU) with byte enables, optional write-to-read bypass, an optional hardwired zero register, and a registered write-trace/counter for on-board debug.

Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle write data is forwarded to readers; 0 = readers see the old value.
- ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes.
- AW, $clog2(DEPTH), address width; derived, not overridden.

Ports:
- Clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- RA  in  NUM_RD*AW  read addresses; port k = RA[k*AW +: AW].
- RD  out  NUM_RD*DW  read data; port k = RD[k*DW +: DW]; combinational.
- WE0  in  DW/8  write-port-0 byte enables.
- WA0  in  AW  write-port-0 address.
- WD0  in  DW  write-port-0 data.
- WE1  in  DW/8  write-port-1 byte enables.
- WA1  in  AW  write-port-1 address.
- WD1  in  DW  write-port-1 data.
- TrValid  out  1  a write was committed on the previous edge.
- TrAddr  out  AW  address of the traced write.
- TrData  out  DW  full register value after the traced write.
- WrCount  out  32  number of committed port-writes since reset.

Behaviour:
- Reset (synchronous, active-high): on an edge with Reset=1:
  - all DEPTH registers := 0; TrValid := 0; TrAddr := 0; TrData := 0; WrCount := 0;
  - any write presented in that cycle is discarded.
  - While Reset=1, bypass is suppressed: RD shows storage contents.
- A port "commits" when its byte-enable vector is non-zero, Reset=0, and it does not target address 0 while ZERO_REG=1.
- Byte write: for each lane b with WEx[b]=1, reg[WAx][8b+7:8b] := WDx lane b; other lanes are unchanged. The write becomes visible in storage after the edge (1-cycle latency).
- Same-address collision (WA0==WA1, both committing): merged per lane.
  - A lane enabled on W1 takes WD1.
  - Otherwise a lane enabled on W0 takes WD0.
  - Otherwise the lane keeps the old value.
- Read, BYPASS=1: if RA[k] equals the address of a committing write this cycle, RD[k] = the merged post-write value (same priority rules); otherwise RD[k] = storage.
- Read, BYPASS=0: RD[k] = storage.
- ZERO_REG=1: RD[k] = 0 whenever RA[k]=0, regardless of writes.
- Reads are independent across ports; any number of ports may share an address.
- Trace register, updated every non-reset edge:
  - If W1 commits: TrAddr := WA1, TrData := merged post-write value of WA1.
  - Else if W0 commits: the same using WA0.
  - TrValid := (any commit). If neither port commits, TrValid := 0 and TrAddr/TrData hold.
- WrCount := WrCount + number of committing ports (0, 1 or 2); wraps modulo 2^32.
  - A collision counts 2.
  - Writes to r0 under ZERO_REG do not count.
- Address out of range cannot occur: DEPTH is a power of two.

Decomposition:
- grf_pkg holds:
  - localparam defaults for DW/DEPTH/NUM_RD;
  - the function that computes the number of byte lanes;
  - the trace-record packed typedef {valid, addr, data}.
- One sub-module, grf_lane_merge (combinational): takes the old word, WE0/WD0 and WE1/WD1, and produces the merged word.
  - It is instantiated once per write address for storage update.
  - It is instantiated once per read port for bypass.

Test Plan:
- Reset then fill: W0 with WE0=4'hF, WA0=i, WD0=i+1 for i=0..31. Then read RA0=5, RA1=6 -> RD0=6, RD1=7; r0 reads 0; WrCount=31; TrValid=1 each fill cycle except i=0.
- Byte merge: r3=32'h11223344. Write W0 WE0=4'b0101, WD0=32'hAABBCCDD to r3 -> r3=32'h11BB33DD next cycle; TrData=32'h11BB33DD.
- Collision: WA0=WA1=7 from r7=0; WE0=4'hF, WD0=32'h0; WE1=4'b1100, WD1=32'hFFFF0000 -> r7=32'hFFFF0000; TrAddr=7; WrCount increments by 2.
- Bypass: BYPASS=1, RA0=9, W1 writes r9 with 32'hDEADBEEF -> RD0=32'hDEADBEEF in the same cycle. With BYPASS=0 build -> RD0=old value until the next cycle.
- Zero register: WA0=0, WD0=32'h12345678, WE0=4'hF -> RD(RA=0)=0; TrValid=0; WrCount unchanged.
- Reset mid-operation: Reset=1 in the same cycle as a W0 write to r10=32'h55 -> after the edge r10=0, WrCount=0, TrValid=0; during that cycle RD(RA=10) shows storage, not 32'h55.
